mac_sign_acc_stage: RTL and testbench

MAC_SIGN_ACC_STAGE -- requirements
Module: mac_sign_acc_stage

---
 rtl/mac_sign_acc_stage_pkg.sv | 59 +++++
 rtl/mac_seg_adder.sv | 37 +++
 rtl/mac_sign_acc_stage.sv | 159 +++++++++++++++
 tb/tb_mac_sign_acc_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_sign_acc_stage_pkg.sv
// rtl/mac_sign_acc_stage_pkg.sv - shared cfg bit indices, lane-mode decode and lane geometry helpers
package mac_const;

    localparam int CFG_SIGNED_BIT = 3;
    localparam int CFG_MAC_BIT    = 2;
    localparam int SEG_COUNT      = 4;
    localparam int SINGLE_SCALE   = 1;
    localparam int DUAL_SCALE     = 2;
    localparam int QUAD_SCALE     = 4;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_DUAL   = 2'd1,
        MODE_QUAD   = 2'd2
    } lane_mode_t;

    // cfg[1:0] = 00 and 11 both select single-width lanes
    function automatic lane_mode_t decode_mode(input logic [1:0] sel);
        lane_mode_t m;
        case (sel)
            2'b01:   m = MODE_DUAL;
            2'b10:   m = MODE_QUAD;
            default: m = MODE_SINGLE;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] lane_top_mask(input lane_mode_t m);
        logic [3:0] r;
        case (m)
            MODE_DUAL: r = 4'b1010;
            MODE_QUAD: r = 4'b1000;
            default:   r = 4'b1111;
        endcase
        return r;
    endfunction

    // Bit k set means no carry enters segment k from segment k-1
    function automatic logic [3:1] lane_cut_mask(input lane_mode_t m);
        logic [3:1] r;
        case (m)
            MODE_DUAL: r = 3'b010;
            MODE_QUAD: r = 3'b000;
            default:   r = 3'b111;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] lane_top_seg(input lane_mode_t m, input logic [1:0] seg);
        logic [1:0] r;
        case (m)
            MODE_DUAL: r = {seg[1], 1'b1};
            MODE_QUAD: r = 2'd3;
            default:   r = seg;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mac_seg_adder.sv
// rtl/mac_seg_adder.sv - four-segment adder with carries cut at lane boundaries
module mac_seg_adder
    import mac_const::*;
#(
    parameter int SEG_WIDTH = 32
) (
    input  logic [4*SEG_WIDTH-1:0] a,
    input  logic [4*SEG_WIDTH-1:0] b,
    input  logic [1:0]             mode,
    output logic [4*SEG_WIDTH-1:0] sum,
    output logic [3:0]             carry,
    output logic [3:0]             ovf
);

    logic [3:1] w_cut;
    logic [3:0] w_cin;
    logic [SEG_WIDTH:0] w_seg [SEG_COUNT];

    assign w_cut = lane_cut_mask(lane_mode_t'(mode));

    for (genvar g = 0; g < SEG_COUNT; g++) begin : g_seg
        localparam int LO = g * SEG_WIDTH;
        localparam int HI = LO + SEG_WIDTH - 1;

        if (g == 0) begin : g_c0
            assign w_cin[g] = 1'b0;
        end else begin : g_cn
            assign w_cin[g] = carry[g-1] & ~w_cut[g];
        end

        assign w_seg[g] = {1'b0, a[HI:LO]} + {1'b0, b[HI:LO]} + {{SEG_WIDTH{1'b0}}, w_cin[g]};
        assign sum[HI:LO] = w_seg[g][SEG_WIDTH-1:0];
        assign carry[g]   = w_seg[g][SEG_WIDTH];
        assign ovf[g]     = (a[HI] == b[HI]) && (w_seg[g][SEG_WIDTH-1] != a[HI]);
    end

endmodule

// File: rtl/mac_sign_acc_stage.sv
// rtl/mac_sign_acc_stage.sv - signed/unsigned lane-split accumulator stage; MAC_ACC_SAT_EN enables overflow saturation
module mac_sign_acc_stage
    import mac_const::*;
#(
    parameter int MAC_CONF_WIDTH = 4,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_MULT_WIDTH = 2 * MAC_MIN_WIDTH,
    parameter int MAC_ACC_WIDTH  = 2 * MAC_MULT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [MAC_CONF_WIDTH-1:0]   cfg,
    input  logic                        valid_in,
    input  logic                        clr_acc,
    input  logic [4*MAC_MULT_WIDTH-1:0] prod_in,
    input  logic [3:0]                  neg_in,
    output logic [4*MAC_ACC_WIDTH-1:0]  acc_out,
    output logic                        valid_out,
    output logic [3:0]                  ovf_out
);

    localparam int MW = MAC_MULT_WIDTH;
    localparam int AW = MAC_ACC_WIDTH;

    logic                      w_signed;
    lane_mode_t                w_mode_in;
    logic [4*AW-1:0]           w_ext_single;
    logic [4*AW-1:0]           w_ext_dual;
    logic [4*AW-1:0]           w_ext_quad;
    logic [4*AW-1:0]           w_ext;

    logic [MAC_CONF_WIDTH-1:0] r_cfg;
    logic                      r_clr;
    logic                      r_valid;
    logic [4*AW-1:0]           r_prod;

    logic [4*AW-1:0]           r_acc;
    logic [MAC_CONF_WIDTH-1:0] r_acc_cfg;
    logic                      r_valid_out;
    logic [3:0]                r_ovf;

    lane_mode_t                w_mode_s1;
    logic                      w_load;
    logic [4*AW-1:0]           w_sum;
    logic [3:0]                w_seg_carry;
    logic [3:0]                w_seg_ovf;
    logic [3:0]                w_lane_ovf;
    logic [4*AW-1:0]           w_acc_next;

    assign w_signed  = cfg[CFG_SIGNED_BIT];
    assign w_mode_in = decode_mode(cfg[1:0]);

    // Negate inside the lane's own product width so magnitude 2^(w-1) lands on the most-negative code
    for (genvar g = 0; g < 4; g++) begin : g_single
        logic [SINGLE_SCALE*MW-1:0] w_mag;
        logic [SINGLE_SCALE*MW-1:0] w_val;
        assign w_mag = prod_in[g*MW +: MW];
        assign w_val = (w_signed & neg_in[g]) ? -w_mag : w_mag;
        assign w_ext_single[g*AW +: AW] = {{(AW-MW){w_signed & w_val[MW-1]}}, w_val};
    end

    for (genvar g = 0; g < 2; g++) begin : g_dual
        logic [DUAL_SCALE*MW-1:0] w_mag;
        logic [DUAL_SCALE*MW-1:0] w_val;
        assign w_mag = prod_in[g*2*MW +: 2*MW];
        assign w_val = (w_signed & neg_in[2*g+1]) ? -w_mag : w_mag;
        assign w_ext_dual[g*2*AW +: 2*AW] = {{(2*AW-2*MW){w_signed & w_val[2*MW-1]}}, w_val};
    end

    logic [QUAD_SCALE*MW-1:0] w_quad_val;
    assign w_quad_val = (w_signed & neg_in[3]) ? -prod_in : prod_in;
    assign w_ext_quad = {{(4*AW-4*MW){w_signed & w_quad_val[4*MW-1]}}, w_quad_val};

    always_comb begin
        case (w_mode_in)
            MODE_DUAL: w_ext = w_ext_dual;
            MODE_QUAD: w_ext = w_ext_quad;
            default:   w_ext = w_ext_single;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg   <= '0;
            r_clr   <= 1'b0;
            r_valid <= 1'b0;
            r_prod  <= '0;
        end else if (en) begin
            r_cfg   <= cfg;
            r_clr   <= clr_acc;
            r_valid <= valid_in;
            r_prod  <= w_ext;
        end
    end

    assign w_mode_s1 = decode_mode(r_cfg[1:0]);
    // A mode change makes the stored lanes meaningless, so it forces a load
    assign w_load = !r_cfg[CFG_MAC_BIT] || r_clr || (r_acc_cfg != r_cfg);

    mac_seg_adder #(
        .SEG_WIDTH (AW)
    ) u_adder (
        .a     (r_acc),
        .b     (r_prod),
        .mode  (w_mode_s1),
        .sum   (w_sum),
        .carry (w_seg_carry),
        .ovf   (w_seg_ovf)
    );

    assign w_lane_ovf = lane_top_mask(w_mode_s1)
                      & (r_cfg[CFG_SIGNED_BIT] ? w_seg_ovf : w_seg_carry);

`ifdef MAC_ACC_SAT_EN
    logic [3:0] w_seg_neg;
    for (genvar g = 0; g < 4; g++) begin : g_sat
        logic [1:0]    w_top;
        logic          w_is_top;
        logic [AW-1:0] w_sat;
        assign w_seg_neg[g] = r_acc[g*AW + AW - 1];
        assign w_top    = lane_top_seg(w_mode_s1, 2'(g));
        assign w_is_top = (w_top == 2'(g));
        // Signed overflow needs equal operand signs, so the old acc sign picks the rail
        assign w_sat = !r_cfg[CFG_SIGNED_BIT] ? '1 :
                       w_seg_neg[w_top] ? (w_is_top ? {1'b1, {(AW-1){1'b0}}} : '0) :
                                          (w_is_top ? {1'b0, {(AW-1){1'b1}}} : '1);
        assign w_acc_next[g*AW +: AW] = w_lane_ovf[w_top] ? w_sat : w_sum[g*AW +: AW];
    end
`else
    assign w_acc_next = w_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_acc_cfg   <= '0;
            r_valid_out <= 1'b0;
            r_ovf       <= '0;
        end else if (en) begin
            r_valid_out <= r_valid;
            if (r_valid) begin
                r_acc_cfg <= r_cfg;
                if (w_load) begin
                    r_acc <= r_prod;
                    r_ovf <= '0;
                end else begin
                    r_acc <= w_acc_next;
                    r_ovf <= w_lane_ovf;
                end
            end
        end
    end

    assign acc_out   = r_acc;
    assign valid_out = r_valid_out;
    assign ovf_out   = r_ovf;

endmodule

// File: tb/tb_mac_sign_acc_stage.sv
// tb/tb_mac_sign_acc_stage.sv - directed scoreboard bench for mac_sign_acc_stage (default and narrow instances)
module tb_mac_sign_acc_stage;

    logic         clk;
    logic         rst;
    logic         en;
    logic [3:0]   cfg;
    logic         valid_in;
    logic         clr_acc;
    logic [63:0]  prod_in;
    logic [3:0]   neg_in;
    logic [127:0] acc_out;
    logic         valid_out;
    logic [3:0]   ovf_out;

    logic         s_en;
    logic [3:0]   s_cfg;
    logic         s_valid_in;
    logic         s_clr_acc;
    logic [31:0]  s_prod_in;
    logic [3:0]   s_neg_in;
    logic [63:0]  s_acc_out;
    logic         s_valid_out;
    logic [3:0]   s_ovf_out;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [127:0] acc;
        logic [3:0]   ovf;
        int           id;
    } sb_t;
    sb_t sb_q[$];
    int  beat_id = 0;
    logic en_at_edge = 1'b0;

    mac_sign_acc_stage u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg       (cfg),
        .valid_in  (valid_in),
        .clr_acc   (clr_acc),
        .prod_in   (prod_in),
        .neg_in    (neg_in),
        .acc_out   (acc_out),
        .valid_out (valid_out),
        .ovf_out   (ovf_out)
    );

    mac_sign_acc_stage #(
        .MAC_MIN_WIDTH (4)
    ) u_small (
        .clk       (clk),
        .rst       (rst),
        .en        (s_en),
        .cfg       (s_cfg),
        .valid_in  (s_valid_in),
        .clr_acc   (s_clr_acc),
        .prod_in   (s_prod_in),
        .neg_in    (s_neg_in),
        .acc_out   (s_acc_out),
        .valid_out (s_valid_out),
        .ovf_out   (s_ovf_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) en_at_edge <= en;

    always @(negedge clk) begin
        if (en_at_edge && valid_out) begin
            n_cmp++;
            assert (sb_q.size() != 0)
            else begin
                n_err++;
                $error("FAIL sb_unexpected_valid: observed acc=%h, no beat expected", acc_out);
            end
            if (sb_q.size() != 0) begin
                sb_t e;
                e = sb_q.pop_front();
                n_cmp++;
                assert (acc_out === e.acc)
                else begin
                    n_err++;
                    $error("FAIL sb_acc beat %0d: observed %h expected %h", e.id, acc_out, e.acc);
                end
                n_cmp++;
                assert (ovf_out === e.ovf)
                else begin
                    n_err++;
                    $error("FAIL sb_ovf beat %0d: observed %h expected %h", e.id, ovf_out, e.ovf);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [3:0] c, input logic clr, input logic [63:0] p,
                        input logic [3:0] n, input logic [127:0] exp_acc, input logic [3:0] exp_ovf);
        sb_t e;
        cfg      = c;
        clr_acc  = clr;
        prod_in  = p;
        neg_in   = n;
        valid_in = 1'b1;
        e.acc = exp_acc;
        e.ovf = exp_ovf;
        e.id  = beat_id;
        beat_id++;
        sb_q.push_back(e);
        step();
    endtask

    task automatic idle(input int cycles);
        valid_in = 1'b0;
        clr_acc  = 1'b0;
        repeat (cycles) step();
    endtask

    logic [127:0] snap_acc;
    logic         snap_valid;
    logic [3:0]   snap_ovf;
    logic [63:0]  exp_sat;

    initial begin
        rst = 1'b1; en = 1'b1; cfg = '0; valid_in = 1'b0; clr_acc = 1'b0;
        prod_in = '0; neg_in = '0;
        s_en = 1'b1; s_cfg = '0; s_valid_in = 1'b0; s_clr_acc = 1'b0;
        s_prod_in = '0; s_neg_in = '0;
        repeat (2) step();
        chk("reset_acc", acc_out, '0);
        chk("reset_valid", {127'd0, valid_out}, 128'd0);
        chk("reset_ovf", {124'd0, ovf_out}, 128'd0);
        rst = 1'b0;

        // single signed mac, two beats, latency and lane-cut carries
        beat(4'hC, 1'b0, {4{16'h0006}}, 4'hF, {4{32'hFFFFFFFA}}, 4'h0);
        chk("lat_first_edge_low", {127'd0, valid_out}, 128'd0);
        beat(4'hC, 1'b0, {4{16'h0006}}, 4'hF, {4{32'hFFFFFFF4}}, 4'h0);
        chk("lat_second_edge_high", {127'd0, valid_out}, 128'd1);
        idle(1);
        chk("lat_third_edge_high", {127'd0, valid_out}, 128'd1);
        idle(1);
        chk("lat_drain_low", {127'd0, valid_out}, 128'd0);

        // dual signed mul
        beat(4'h9, 1'b0, 64'h0000_0002_0000_0001, 4'b0010,
             {64'h0000_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF}, 4'h0);

        // quad unsigned mac crossing the 64-bit segment boundary
        beat(4'h6, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'h0, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 4'h0);
        beat(4'h6, 1'b0, 64'h1, 4'hF, 128'h1_0000_0000_0000_0000, 4'h0);

        // most-negative product and negative zero
        beat(4'h8, 1'b0, {16'h8000, 16'h0000, 16'h7FFF, 16'h0001}, 4'b1100,
             {32'hFFFF8000, 32'h0, 32'h00007FFF, 32'h1}, 4'h0);

        // unsigned single mac, then mode change to dual without clr_acc
        beat(4'h4, 1'b0, {16'h1, 16'h2, 16'h3, 16'h4}, 4'hF, {32'h1, 32'h2, 32'h3, 32'h4}, 4'h0);
        beat(4'h4, 1'b0, {16'h1, 16'h2, 16'h3, 16'h4}, 4'hF, {32'h2, 32'h4, 32'h6, 32'h8}, 4'h0);
        beat(4'h5, 1'b0, 64'h0000_0007_0000_0005, 4'h0, {64'h7, 64'h5}, 4'h0);
        beat(4'h5, 1'b0, 64'h0000_0007_0000_0005, 4'h0, {64'hE, 64'hA}, 4'h0);
        beat(4'h5, 1'b0, 64'h0000_0001_0000_0001, 4'h0, {64'hF, 64'hB}, 4'h0);

        // three stalled cycles with junk on the inputs
        en = 1'b0; valid_in = 1'b1; clr_acc = 1'b1; prod_in = '1; cfg = 4'hC;
        snap_acc = acc_out; snap_valid = valid_out; snap_ovf = ovf_out;
        chk("stall_snapshot_acc", snap_acc, {64'hE, 64'hA});
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_acc_frozen", acc_out, snap_acc);
            chk("stall_valid_frozen", {127'd0, valid_out}, {127'd0, snap_valid});
            chk("stall_ovf_frozen", {124'd0, ovf_out}, {124'd0, snap_ovf});
        end
        en = 1'b1;
        idle(2);

        // reset with two beats in flight: neither may emerge
        cfg = 4'hC; clr_acc = 1'b0; neg_in = 4'h0; prod_in = {4{16'h0005}}; valid_in = 1'b1;
        step();
        prod_in = {4{16'h0009}}; rst = 1'b1;
        step();
        chk("rst_mid_acc", acc_out, '0);
        chk("rst_mid_valid", {127'd0, valid_out}, 128'd0);
        chk("rst_mid_ovf", {124'd0, ovf_out}, 128'd0);
        rst = 1'b0;
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_stale_valid", {127'd0, valid_out}, 128'd0);
        end
        beat(4'hC, 1'b0, {4{16'h0006}}, 4'h0, {4{32'h6}}, 4'h0);
        idle(3);

        // narrow instance: drive each lane to 0x7FF0 then overflow it
        s_cfg = 4'hC; s_clr_acc = 1'b1; s_valid_in = 1'b1; s_prod_in = {4{8'h7F}};
        step();
        s_clr_acc = 1'b0;
        repeat (256) step();
        s_prod_in = {4{8'h71}};
        step();
        s_valid_in = 1'b0;
        repeat (2) step();
        chk("narrow_pre_ovf_acc", {64'd0, s_acc_out}, {64'd0, {4{16'h7FF0}}});
        chk("narrow_pre_ovf_flag", {124'd0, s_ovf_out}, 128'd0);
        s_prod_in = {4{8'h20}}; s_valid_in = 1'b1;
        step();
        s_valid_in = 1'b0;
        repeat (2) step();
`ifdef MAC_ACC_SAT_EN
        exp_sat = {4{16'h7FFF}};
`else
        exp_sat = {4{16'h8010}};
`endif
        chk("narrow_ovf_acc", {64'd0, s_acc_out}, {64'd0, exp_sat});
        chk("narrow_ovf_flag", {124'd0, s_ovf_out}, {124'd0, 4'hF});
        s_prod_in = {4{8'h01}}; s_clr_acc = 1'b1; s_valid_in = 1'b1;
        step();
        s_valid_in = 1'b0; s_clr_acc = 1'b0;
        step();
        chk("narrow_clr_valid", {127'd0, s_valid_out}, 128'd1);
        chk("narrow_clr_acc", {64'd0, s_acc_out}, {64'd0, {4{16'h0001}}});
        chk("narrow_clr_ovf", {124'd0, s_ovf_out}, 128'd0);

        idle(2);
        chk("sb_drained", 128'(sb_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
